pool_stream_engine: RTL and testbench

Streaming 2D pooling engine for the max-pooling datapath. It accepts one pixel per handshake in raster order and forms KERNEL_DIM×KERNEL_DIM windows from internal line buffers. It emits only windows that lie fully inside the image and sit on the STRIDE grid, reducing each one by max or floor-average. It sits between the pixel source and the downstream feature-map consumer, with valid/ready backpressure on both sides.

---
 rtl/pool_pkg.sv | 22 ++
 rtl/pool_stream_engine_if.sv | 29 ++
 rtl/pool_line_buffer.sv | 34 +++
 rtl/pool_stream_engine.sv | 168 ++++++++++++++++
 tb/tb_pool_stream_engine.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared types and helpers for the streaming pooling engine.
// Contents:
//   pool_mode_e     - reduction selector (POOL_MAX / POOL_AVG)
//   pool_out_count  - number of pooled outputs produced per frame
//   pool_sum_width  - accumulator width that holds a full KxK window sum
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  function automatic int pool_out_count(input int img_w, input int img_h,
                                        input int k, input int stride);
    return ((img_w - k) / stride + 1) * ((img_h - k) / stride + 1);
  endfunction

  function automatic int pool_sum_width(input int data_width, input int k);
    return data_width + $clog2(k * k);
  endfunction

endpackage

// File: rtl/pool_stream_engine_if.sv
// pool_stream_engine_if: pixel-in / result-out stream bundle for the pooling engine.
// Signals:
//   in_data, in_valid, in_ready    - input pixel handshake (source -> engine)
//   out_data, out_valid, out_ready - pooled result handshake (engine -> consumer)
//   out_last                       - marks the final pooled result of a frame
// Modports:
//   master - the environment side (drives pixels, accepts results)
//   slave  - the engine side
interface pool_stream_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: DEPTH-deep, DATA_WIDTH-wide delay line that shifts only when
// enabled. With DEPTH equal to the image width, dout is the pixel from the same
// column one row earlier.
// Ports:
//   clk  - clock
//   en   - shift enable (one position per accepted pixel)
//   din  - pixel entering the line
//   dout - pixel leaving the line, DEPTH enabled shifts after it entered
module pool_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] taps [DEPTH];

  // Contents are never reset: the first rows of every frame are never
  // eligible for output, so stale data cannot reach the result.
  always_ff @(posedge clk) begin
    if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/pool_stream_engine.sv
// pool_stream_engine: streaming KxK pooling (max or floor-average) over a raster
// pixel stream, emitting only windows fully inside the image on the STRIDE grid.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   mode - 0 = POOL_MAX, 1 = POOL_AVG; latched when pixel (0,0) is accepted
//   bus  - stream bundle (slave side): in_* pixel input, out_* pooled output
module pool_stream_engine
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3,
  parameter int STRIDE     = 2,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  pool_stream_engine_if.slave  bus
);

  localparam int K  = KERNEL_DIM;
  localparam int KK = K * K;
  localparam int SW = pool_sum_width(DATA_WIDTH, K);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_K    = CW'(K - 1);
  localparam logic [CW-1:0] COL_FIN  = CW'(K - 1 + ((IMG_W - K) / STRIDE) * STRIDE);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(K - 1);
  localparam logic [RW-1:0] ROW_FIN  = RW'(K - 1 + ((IMG_H - K) / STRIDE) * STRIDE);
  localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [PW-1:0]         col_ph;
  logic [PW-1:0]         row_ph;
  pool_mode_e            mode_q;
  logic [DATA_WIDTH-1:0] win      [K][K];
  logic [DATA_WIDTH-1:0] win_next [K][K];
  logic [DATA_WIDTH-1:0] lb_in    [K-1];
  logic [DATA_WIDTH-1:0] lb_out   [K-1];
  logic [DATA_WIDTH-1:0] max_val;
  logic [SW-1:0]         sum_val;
  logic [SW-1:0]         avg_val;
  logic [DATA_WIDTH-1:0] result;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic                  in_ready_int;
  logic                  accept;
  logic                  eligible;
  logic                  final_pos;

  assign in_ready_int  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && in_ready_int;
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  // Chain of line buffers: buffer 0 delays the incoming pixel by one row,
  // buffer i delays by i+1 rows, so the last buffer holds the oldest row.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_first
      assign lb_in[i] = bus.in_data;
    end else begin : g_rest
      assign lb_in[i] = lb_out[i-1];
    end
    pool_line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_W)
    ) u_line_buffer (
      .clk (clk),
      .en  (accept),
      .din (lb_in[i]),
      .dout(lb_out[i])
    );
  end

  // Window after this accept: shift left, new right column is the line-buffer
  // taps (oldest row on top) with the incoming pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_next[r][c] = win[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_next[r][K-1] = lb_out[K-2-r];
    end
    win_next[K-1][K-1] = bus.in_data;
  end

  // Reduce the post-accept window so the result registers on the same edge.
  always_comb begin
    max_val = '0;
    sum_val = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (win_next[r][c] > max_val) begin
          max_val = win_next[r][c];
        end
        sum_val = sum_val + SW'(win_next[r][c]);
      end
    end
    avg_val = sum_val / SW'(KK);
    result  = (mode_q == POOL_AVG) ? DATA_WIDTH'(avg_val) : max_val;
  end

  // Phase counters are zero exactly on the stride grid once the window is full.
  assign eligible  = (col >= COL_K) && (row >= ROW_K) && (col_ph == '0) && (row_ph == '0);
  assign final_pos = (col == COL_FIN) && (row == ROW_FIN);

  // Position/phase tracking, window shift and the output register. A stalled
  // output blocks accept, which freezes every piece of state here.
  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      col_ph      <= '0;
      row_ph      <= '0;
      mode_q      <= POOL_MAX;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        win <= win_next;
        if ((col == '0) && (row == '0)) begin
          mode_q <= pool_mode_e'(mode);
        end
        if (col == COL_LAST) begin
          col    <= '0;
          col_ph <= '0;
          if (row == ROW_LAST) begin
            row    <= '0;
            row_ph <= '0;
          end else begin
            row    <= row + 1'b1;
            row_ph <= ((row < ROW_K) || (row_ph == PH_LAST)) ? '0 : row_ph + 1'b1;
          end
        end else begin
          col    <= col + 1'b1;
          col_ph <= ((col < COL_K) || (col_ph == PH_LAST)) ? '0 : col_ph + 1'b1;
        end
        if (eligible) begin
          out_valid_q <= 1'b1;
          out_data_q  <= result;
          out_last_q  <= final_pos;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_stream_engine.sv
// tb_pool_stream_engine: self-checking bench for pool_stream_engine.
// Two engines run side by side: dut_a (6x6, K=2, S=2) and dut_b (5x5, K=3, S=1).
// A reference model fills a scoreboard queue on every accepted pixel; each
// observed output handshake pops and compares against it.
module tb_pool_stream_engine;
  import pool_pkg::*;

  localparam int AW = 6;
  localparam int AK = 2;
  localparam int AS = 2;
  localparam int BW = 5;
  localparam int BK = 3;
  localparam int BS = 1;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } out_t;

  logic clk;
  logic rst;
  logic mode_a;
  logic mode_b;

  pool_stream_engine_if #(.DATA_WIDTH(8)) ifa ();
  pool_stream_engine_if #(.DATA_WIDTH(8)) ifb ();

  pool_stream_engine #(
    .DATA_WIDTH(8), .KERNEL_DIM(AK), .STRIDE(AS), .IMG_W(AW), .IMG_H(AW)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .mode(mode_a),
    .bus (ifa)
  );

  pool_stream_engine #(
    .DATA_WIDTH(8), .KERNEL_DIM(BK), .STRIDE(BS), .IMG_W(BW), .IMG_H(BW)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .mode(mode_b),
    .bus (ifb)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  out_t exp_a[$];
  out_t got_a[$];
  out_t exp_b[$];
  out_t got_b[$];
  int   img [2][8][8];
  int   m_col [2];
  int   m_row [2];
  int   m_mode [2];
  int   acc_cyc_b [25];
  int   first_valid_b;
  int   max_ref [9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
  int   avg_ref [9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
  int   k3_ref  [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: record the accepted pixel, latch mode at (0,0) and push
  // the expected result whenever a full window lands on the stride grid.
  task automatic model_accept(input int which, input logic [7:0] pix, input logic m);
    int   w, k, s, c, r, mx, sum;
    out_t e;
    w = (which == 0) ? AW : BW;
    k = (which == 0) ? AK : BK;
    s = (which == 0) ? AS : BS;
    c = m_col[which];
    r = m_row[which];
    img[which][r][c] = int'(pix);
    if (c == 0 && r == 0) m_mode[which] = int'(m);
    if (c >= k - 1 && r >= k - 1 && (c - k + 1) % s == 0 && (r - k + 1) % s == 0) begin
      mx  = 0;
      sum = 0;
      for (int rr = r - k + 1; rr <= r; rr++) begin
        for (int cc = c - k + 1; cc <= c; cc++) begin
          if (img[which][rr][cc] > mx) mx = img[which][rr][cc];
          sum += img[which][rr][cc];
        end
      end
      e.data = (m_mode[which] == 1) ? 8'(sum / (k * k)) : 8'(mx);
      e.last = (c + s > w - 1) && (r + s > w - 1);
      if (which == 0) exp_a.push_back(e);
      else exp_b.push_back(e);
    end
    if (c == w - 1) begin
      m_col[which] = 0;
      m_row[which] = (r == w - 1) ? 0 : r + 1;
    end else begin
      m_col[which] = c + 1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_col[i]  = 0;
      m_row[i]  = 0;
      m_mode[i] = 0;
    end
    exp_a.delete();
    exp_b.delete();
    got_a.delete();
    got_b.delete();
  endtask

  // One clock: observe at the falling edge (output handshake, pixel accept),
  // score any output, then return just after the next rising edge.
  task automatic tick(input int which, output logic acc);
    out_t o;
    out_t e;
    @(negedge clk);
    cyc++;
    acc = 1'b0;
    if (which == 0) begin
      if (ifa.out_valid && ifa.out_ready) begin
        o = {ifa.out_last, ifa.out_data};
        got_a.push_back(o);
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("[TB] FAIL a_scoreboard_extra: got data=%0d last=%0b, required no output", o.data, o.last);
        end else begin
          e = exp_a.pop_front();
          if (o !== e) begin
            errors++;
            $display("[TB] FAIL a_scoreboard: got data=%0d last=%0b, required data=%0d last=%0b",
                     o.data, o.last, e.data, e.last);
          end
        end
      end
      if (ifa.in_valid && ifa.in_ready) begin
        acc = 1'b1;
        model_accept(0, ifa.in_data, mode_a);
      end
    end else begin
      if (ifb.out_valid && first_valid_b < 0) first_valid_b = cyc;
      if (ifb.out_valid && ifb.out_ready) begin
        o = {ifb.out_last, ifb.out_data};
        got_b.push_back(o);
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("[TB] FAIL b_scoreboard_extra: got data=%0d last=%0b, required no output", o.data, o.last);
        end else begin
          e = exp_b.pop_front();
          if (o !== e) begin
            errors++;
            $display("[TB] FAIL b_scoreboard: got data=%0d last=%0b, required data=%0d last=%0b",
                     o.data, o.last, e.data, e.last);
          end
        end
      end
      if (ifb.in_valid && ifb.in_ready) begin
        acc = 1'b1;
        if (m_row[1] * BW + m_col[1] < 25) acc_cyc_b[m_row[1] * BW + m_col[1]] = cyc;
        model_accept(1, ifb.in_data, mode_b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] pix, input logic m);
    logic acc;
    int   n;
    if (which == 0) begin
      ifa.in_data  = pix;
      ifa.in_valid = 1'b1;
      mode_a       = m;
    end else begin
      ifb.in_data  = pix;
      ifb.in_valid = 1'b1;
      mode_b       = m;
    end
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      tick(which, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: pixel %0d accepted=0, required accept within 50 cycles", pix);
    end
  endtask

  task automatic drain(input int which);
    logic acc;
    int   n;
    n = 0;
    if (which == 0) ifa.in_valid = 1'b0;
    else ifb.in_valid = 1'b0;
    while (((which == 0) ? ifa.out_valid : ifb.out_valid) && n < 40) begin
      tick(which, acc);
      n++;
    end
    if ((which == 0) ? ifa.out_valid : ifb.out_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: out_valid=1 after 40 cycles, required 0");
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    mode_a       = 1'b0;
    mode_b       = 1'b0;
    ifa.in_valid = 1'b0;
    ifa.in_data  = '0;
    ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0;
    ifb.in_data  = '0;
    ifb.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.out_data !== 8'd0 || ifa.out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_a: in_ready=%b out_valid=%b out_data=%0d out_last=%b, required 1 0 0 0",
               ifa.in_ready, ifa.out_valid, ifa.out_data, ifa.out_last);
    end
    checks++;
    if (ifb.in_ready !== 1'b1 || ifb.out_valid !== 1'b0 || ifb.out_data !== 8'd0 || ifb.out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_b: in_ready=%b out_valid=%b out_data=%0d out_last=%b, required 1 0 0 0",
               ifb.in_ready, ifb.out_valid, ifb.out_data, ifb.out_last);
    end
  endtask

  task automatic test_max_frame();
    for (int i = 0; i < 36; i++) send(0, 8'(i), 1'b0);
    drain(0);
    checks++;
    if (got_a.size() !== 9 || exp_a.size() !== 0) begin
      errors++;
      $display("[TB] FAIL max_count: got %0d outputs (%0d missing), required 9 (0 missing)", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < got_a.size() && i < 9; i++) begin
      checks++;
      if (got_a[i].data !== 8'(max_ref[i]) || got_a[i].last !== (i == 8)) begin
        errors++;
        $display("[TB] FAIL max_out[%0d]: got data=%0d last=%b, required data=%0d last=%b",
                 i, got_a[i].data, got_a[i].last, max_ref[i], (i == 8));
      end
    end
    got_a.delete();
  endtask

  task automatic test_avg_frame();
    for (int i = 0; i < 36; i++) send(0, 8'(i), 1'b1);
    drain(0);
    checks++;
    if (got_a.size() !== 9 || exp_a.size() !== 0) begin
      errors++;
      $display("[TB] FAIL avg_count: got %0d outputs (%0d missing), required 9 (0 missing)", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < got_a.size() && i < 9; i++) begin
      checks++;
      if (got_a[i].data !== 8'(avg_ref[i]) || got_a[i].last !== (i == 8)) begin
        errors++;
        $display("[TB] FAIL avg_out[%0d]: got data=%0d last=%b, required data=%0d last=%b",
                 i, got_a[i].data, got_a[i].last, avg_ref[i], (i == 8));
      end
    end
    got_a.delete();
  endtask

  task automatic test_k3_stride1();
    first_valid_b = -1;
    for (int i = 0; i < 25; i++) send(1, 8'(i), 1'b0);
    drain(1);
    checks++;
    if (got_b.size() !== 9 || exp_b.size() !== 0) begin
      errors++;
      $display("[TB] FAIL k3_count: got %0d outputs (%0d missing), required 9 (0 missing)", got_b.size(), exp_b.size());
    end
    for (int i = 0; i < got_b.size() && i < 9; i++) begin
      checks++;
      if (got_b[i].data !== 8'(k3_ref[i]) || got_b[i].last !== (i == 8)) begin
        errors++;
        $display("[TB] FAIL k3_out[%0d]: got data=%0d last=%b, required data=%0d last=%b",
                 i, got_b[i].data, got_b[i].last, k3_ref[i], (i == 8));
      end
    end
    checks++;
    if (first_valid_b !== acc_cyc_b[12] + 1) begin
      errors++;
      $display("[TB] FAIL k3_latency: first out_valid at cycle %0d, required %0d",
               first_valid_b, acc_cyc_b[12] + 1);
    end
    got_b.delete();
  endtask

  task automatic test_backpressure();
    logic       acc;
    logic [7:0] held;
    for (int i = 0; i < 8; i++) send(0, 8'(i), 1'b0);
    held = ifa.out_data;
    checks++;
    if (ifa.out_valid !== 1'b1 || held !== 8'd7) begin
      errors++;
      $display("[TB] FAIL bp_first: out_valid=%b out_data=%0d, required 1 and 7", ifa.out_valid, held);
    end
    ifa.out_ready = 1'b0;
    ifa.in_data   = 8'd8;
    ifa.in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(0, acc);
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.out_data !== held || ifa.in_ready !== 1'b0 || acc !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: out_valid=%b out_data=%0d in_ready=%b accepted=%b, required 1 %0d 0 0",
                 c, ifa.out_valid, ifa.out_data, ifa.in_ready, acc, held);
      end
    end
    ifa.out_ready = 1'b1;
    for (int i = 8; i < 36; i++) send(0, 8'(i), 1'b0);
    drain(0);
    checks++;
    if (got_a.size() !== 9 || exp_a.size() !== 0) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d outputs (%0d missing), required 9 (0 missing)", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < got_a.size() && i < 9; i++) begin
      checks++;
      if (got_a[i].data !== 8'(max_ref[i])) begin
        errors++;
        $display("[TB] FAIL bp_out[%0d]: got %0d, required %0d", i, got_a[i].data, max_ref[i]);
      end
    end
    got_a.delete();
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic start;
    int   lasts;
    int   first_last;
    for (int f = 0; f < 2; f++) begin
      start = (f == 0) ? 1'b1 : 1'b0;
      for (int i = 0; i < 36; i++) begin
        ifa.in_valid = 1'b0;
        mode_a       = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) tick(0, acc);
        send(0, 8'($urandom_range(0, 255)), (i < 15) ? start : !start);
      end
    end
    drain(0);
    lasts      = 0;
    first_last = -1;
    for (int i = 0; i < got_a.size(); i++) begin
      if (got_a[i].last) begin
        lasts++;
        if (first_last < 0) first_last = i;
      end
    end
    checks++;
    if (got_a.size() !== 18 || first_last !== 8 || lasts !== 2 || exp_a.size() !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_frames: got %0d outputs, first last at %0d, %0d lasts, %0d missing; required 18, 8, 2, 0",
               got_a.size(), first_last, lasts, exp_a.size());
    end
    got_a.delete();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 20; i++) send(0, 8'(i), 1'b0);
    checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== 8'd19) begin
      errors++;
      $display("[TB] FAIL rst_pending: out_valid=%b out_data=%0d, required 1 and 19", ifa.out_valid, ifa.out_data);
    end
    rst          = 1'b1;
    ifa.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 8'd0 || ifa.out_last !== 1'b0 || ifa.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mid_state: out_valid=%b out_data=%0d out_last=%b in_ready=%b, required 0 0 0 1",
               ifa.out_valid, ifa.out_data, ifa.out_last, ifa.in_ready);
    end
    for (int i = 0; i < 36; i++) send(0, 8'(i), 1'b0);
    drain(0);
    checks++;
    if (got_a.size() !== 9 || exp_a.size() !== 0) begin
      errors++;
      $display("[TB] FAIL rst_count: got %0d outputs (%0d missing), required 9 (0 missing)", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < got_a.size() && i < 9; i++) begin
      checks++;
      if (got_a[i].data !== 8'(max_ref[i]) || got_a[i].last !== (i == 8)) begin
        errors++;
        $display("[TB] FAIL rst_out[%0d]: got data=%0d last=%b, required data=%0d last=%b",
                 i, got_a[i].data, got_a[i].last, max_ref[i], (i == 8));
      end
    end
    got_a.delete();
  endtask

  initial begin
    $display("[TB] pool_stream_engine bench start");
    test_reset();
    test_max_frame();
    test_avg_frame();
    test_k3_stride1();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
